load_store_unit: RTL and testbench

- Sits between the single-cycle RISC-V core's memory stage and the DataMemory word array.
- Turns core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned DataMemory accesses.
- Performs byte-lane extraction with sign or zero extension on loads.
- Performs read-modify-write for byte and halfword stores, because DataMemory only writes whole words. Flags misaligned, illegal and out-of-range accesses.

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_store_unit_align.sv | 37 +++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit types: funct3 encodings, FSM state enum and request decode helpers.
// Pure declarations, no latency or backpressure of its own.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        RESP
    } lsu_state_t;

    // Unsigned widths only exist for loads, so BU/HU with a store is rejected.
    function automatic logic f3_illegal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane extraction with sign/zero extension and byte/halfword merge into a memory word.
// Purely combinational: zero latency, no backpressure.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'd0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'd0, lane_half};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3)
            F3_B:    store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H:    store_word[{offset[1], 4'b0000} +: 16] = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-to-DataMemory load/store FSM: load 3, SW 2, SB/SH 4 (read-modify-write), fault 1 cycle to resp_valid.
// req_ready only in IDLE, the core stalls otherwise. Define LSU_PERF_CNT_EN for load/store/fault counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [31:0]           mem_read_data
`ifdef LSU_PERF_CNT_EN
   ,output logic [31:0]           load_count,
    output logic [31:0]           store_count,
    output logic [31:0]           fault_count
`endif
);

    localparam logic [ADDR_WIDTH-3:0] MEM_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

    lsu_state_t  state;
    logic        op_we;
    logic        op_fault;
    logic [2:0]  op_funct3;
    logic [1:0]  op_offset;
    logic [31:0] op_wdata;
    logic        write_q;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_fault = f3_illegal(req_funct3, req_we)
                     | misaligned(req_funct3, req_addr[1:0])
                     | (req_addr[ADDR_WIDTH-1:2] >= MEM_LIMIT);

    // A reset landing on the WR cycle must not reach DataMemory.
    assign mem_write_enable = write_q & ~rst;

    lsu_align u_align (
        .word       (mem_read_data),
        .offset     (op_offset),
        .funct3     (op_funct3),
        .wdata      (op_wdata[15:0]),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'd0;
            resp_fault      <= 1'b0;
            mem_address     <= '0;
            mem_write_data  <= 32'd0;
            mem_read_enable <= 1'b0;
            write_q         <= 1'b0;
            op_we           <= 1'b0;
            op_fault        <= 1'b0;
            op_funct3       <= 3'd0;
            op_offset       <= 2'd0;
            op_wdata        <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        op_we       <= req_we;
                        op_fault    <= req_fault;
                        op_funct3   <= req_funct3;
                        op_offset   <= req_addr[1:0];
                        op_wdata    <= req_wdata;
                        mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && req_funct3 == F3_W) begin
                            state          <= WR;
                            write_q        <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state           <= RD;
                            mem_read_enable <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    mem_read_enable <= 1'b0;
                    if (op_we) begin
                        state          <= WR;
                        write_q        <= 1'b1;
                        mem_write_data <= store_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                WR: begin
                    state      <= RESP;
                    write_q    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state           <= IDLE;
                    req_ready       <= 1'b1;
                    mem_read_enable <= 1'b0;
                    write_q         <= 1'b0;
                end
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
            fault_count <= 32'd0;
        end else if (state == RESP) begin
            if (op_fault)   fault_count <= fault_count + 32'd1;
            else if (op_we) store_count <= store_count + 32'd1;
            else            load_count  <= load_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations queued at issue, checked on each resp_valid.
// Also checks latency, memory enable counts, write address, mid-op reset and optional counters.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int AW    = 32;
    localparam int WORDS = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_write_enable;
    logic          mem_read_enable;
    logic [31:0]   mem_read_data;
`ifdef LSU_PERF_CNT_EN
    logic [31:0]   load_count;
    logic [31:0]   store_count;
    logic [31:0]   fault_count;
`endif

    load_store_unit #(.ADDR_WIDTH(AW), .MEM_WORDS(WORDS)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
`ifdef LSU_PERF_CNT_EN
       ,.load_count       (load_count),
        .store_count      (store_count),
        .fault_count      (fault_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [WORDS] = '{default: 32'd0};
    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;
    end

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] waddr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   next_id  = 0;
    int   exp_loads = 0, exp_stores = 0, exp_faults = 0;

    int          acc_n = 0, rd_seen = 0, wr_seen = 0, wr_total = 0;
    logic [31:0] wr_addr = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq($sformatf("t%0d_rdata", e.id), resp_rdata, e.rdata);
                check_eq($sformatf("t%0d_fault", e.id), 32'(resp_fault), 32'(e.fault));
                check_eq($sformatf("t%0d_latency", e.id), 32'(cyc - acc_n), 32'(e.lat));
                check_eq($sformatf("t%0d_rd_cycles", e.id), 32'(rd_seen), 32'(e.rd));
                check_eq($sformatf("t%0d_wr_cycles", e.id), 32'(wr_seen), 32'(e.wr));
                if (e.wr != 0) check_eq($sformatf("t%0d_wr_addr", e.id), wr_addr, e.waddr);
            end
        end
        if (mem_read_enable) rd_seen++;
        if (mem_write_enable) begin
            wr_seen++;
            wr_total++;
            wr_addr = mem_address;
        end
        if (req_valid && req_ready && !rst) begin
            acc_n   = cyc;
            rd_seen = 0;
            wr_seen = 0;
        end
    end

    // Called just after a posedge with the DUT idle; returns just after a posedge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_fault, input int lat, input int rd, input int wr);
        exp_t e;
        e.id = next_id; e.rdata = exp_rdata; e.fault = exp_fault;
        e.lat = lat; e.rd = rd; e.wr = wr; e.waddr = {addr[31:2], 2'b00};
        next_id++;
        if (exp_fault) exp_faults++;
        else if (we)   exp_stores++;
        else           exp_loads++;
        sb_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            check_eq("resp_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'd0, exp, 1'b0, 3, 2, 0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        if (f3 == F3_W) issue(1'b1, f3, addr, data, 32'd0, 1'b0, 2, 0, 1);
        else            issue(1'b1, f3, addr, data, 32'd0, 1'b0, 4, 2, 1);
    endtask

    task automatic flt(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        issue(we, f3, addr, 32'h5555_AAAA, 32'd0, 1'b1, 1, 0, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check_eq({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
        check_eq({tag, "_mem_address"}, mem_address, 32'd0);
        check_eq({tag, "_mem_re"}, 32'(mem_read_enable), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
    endtask

    initial begin
        int wr_before;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check_eq("reset_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        st(F3_W, 32'h04, 32'hDEADBEEF);
        ld(F3_W, 32'h04, 32'hDEADBEEF);

        st(F3_W, 32'h08, 32'hCAFEBABE);
        st(F3_B, 32'h09, 32'hFFFFFF11);
        ld(F3_W, 32'h08, 32'hCAFE11BE);
        ld(F3_B, 32'h0B, 32'hFFFFFFCA);
        ld(F3_BU, 32'h0B, 32'h000000CA);
        ld(F3_B, 32'h08, 32'hFFFFFFBE);

        st(F3_W, 32'h0C, 32'h00008000);
        ld(F3_H, 32'h0C, 32'hFFFF8000);
        ld(F3_HU, 32'h0C, 32'h00008000);
        st(F3_H, 32'h0E, 32'hABCD1234);
        ld(F3_W, 32'h0C, 32'h12348000);
        ld(F3_H, 32'h0E, 32'h00001234);

        flt(1'b0, F3_W, 32'h06);
        flt(1'b0, F3_H, 32'h05);
        flt(1'b0, 3'b011, 32'h00);
        flt(1'b1, F3_BU, 32'h00);
        flt(1'b0, F3_W, 32'(WORDS * 4));
        flt(1'b1, F3_H, 32'h01);
        ld(F3_W, 32'(WORDS * 4 - 4), 32'd0);

        // SB interrupted by reset during RD_CAP.
        wr_before = wr_total;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h09; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("rst_midop_no_write", 32'(wr_total), 32'(wr_before));
        check_idle_outputs("rst_midop");
        ld(F3_W, 32'h08, 32'hCAFE11BE);

`ifdef LSU_PERF_CNT_EN
        check_eq("load_count", load_count, 32'(exp_loads));
        check_eq("store_count", store_count, 32'(exp_stores));
        check_eq("fault_count", fault_count, 32'(exp_faults));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("load_count_clr", load_count, 32'd0);
        check_eq("store_count_clr", store_count, 32'd0);
        check_eq("fault_count_clr", fault_count, 32'd0);
        ld(F3_W, 32'h04, 32'hDEADBEEF);
        st(F3_W, 32'h10, 32'h01020304);
        flt(1'b0, 3'b111, 32'h00);
        ld(F3_BU, 32'h10, 32'h00000004);
        check_eq("load_count_2", load_count, 32'd2);
        check_eq("store_count_1", store_count, 32'd1);
        check_eq("fault_count_1", fault_count, 32'd1);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
